debounce_switch: RTL and testbench

- Conditions a raw, bouncing mechanical input (button, switch, encoder contact) into a clean, clock-synchronous level.
- Sits directly upstream of the edge detector: its out_debounced feeds the edge detector's in_signal.
- Synchroniser chain, then a stability counter FSM; the level commits only after STABLE_TICKS consecutive agreeing samples.
- Emits a one-cycle change pulse and a busy flag.

---
 rtl/debounce_pkg.sv | 13 +
 rtl/sync_chain.sv | 29 ++
 rtl/debounce_switch.sv | 108 ++++++++++
 tb/tb_debounce_switch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and helpers for the switch debouncer
package debounce_pkg;

  typedef enum logic {
    DEB_STABLE   = 1'b0,
    DEB_COUNTING = 1'b1
  } t_debounce_state;

  function automatic int deb_cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for an asynchronous single-bit input
module sync_chain #(
  parameter int   SYNC_STEPS = 3,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_signal,
  output logic out_signal
);

  logic [SYNC_STEPS-1:0] sync_q;
  logic [SYNC_STEPS-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STEPS-2:0], in_signal};
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      sync_q <= {SYNC_STEPS{INIT_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign out_signal = sync_q[SYNC_STEPS-1];

endmodule

// File: rtl/debounce_switch.sv
// rtl/debounce_switch.sv - synchronise and debounce a mechanical contact input
// Optional out_rise/out_fall ports are enabled by defining DEBOUNCE_EDGE_OUT_EN.
module debounce_switch
  import debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = 50000,
  parameter int   SYNC_STEPS   = 3,
  parameter logic INIT_LEVEL   = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_signal,
  output logic out_debounced,
  output logic out_changed,
  output logic out_busy
`ifdef DEBOUNCE_EDGE_OUT_EN
  ,
  output logic out_rise,
  output logic out_fall
`endif
);

  localparam int CW = deb_cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic            sync_s;
  t_debounce_state state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            changed_q, changed_d;
  logic            commit;

  sync_chain #(
    .SYNC_STEPS(SYNC_STEPS),
    .INIT_LEVEL(INIT_LEVEL)
  ) u_sync (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_signal (in_signal),
    .out_signal(sync_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    changed_d = 1'b0;
    commit    = 1'b0;
    case (state_q)
      DEB_STABLE: begin
        cnt_d = '0;
        if (sync_s != level_q) begin
          if (STABLE_TICKS == 1) begin
            commit = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = DEB_COUNTING;
          end
        end
      end
      DEB_COUNTING: begin
        // Any agreeing sample rejects the excursion; counting restarts from zero.
        if (sync_s == level_q) begin
          cnt_d   = '0;
          state_d = DEB_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = DEB_STABLE;
      end
    endcase
    if (commit) begin
      level_d   = sync_s;
      changed_d = 1'b1;
      cnt_d     = '0;
      state_d   = DEB_STABLE;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= DEB_STABLE;
      cnt_q     <= '0;
      level_q   <= INIT_LEVEL;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      changed_q <= changed_d;
    end
  end

  assign out_debounced = level_q;
  assign out_changed   = changed_q;
  assign out_busy      = (state_q == DEB_COUNTING);

`ifdef DEBOUNCE_EDGE_OUT_EN
  assign out_rise = changed_q & level_q;
  assign out_fall = changed_q & ~level_q;
`endif

endmodule

// File: tb/tb_debounce_switch.sv
// tb/tb_debounce_switch.sv - directed self-checking bench for debounce_switch
module tb_debounce_switch;

  logic clk;
  logic in_rst;
  logic in_signal;
  logic out_debounced;
  logic out_changed;
  logic out_busy;
`ifdef DEBOUNCE_EDGE_OUT_EN
  logic out_rise;
  logic out_fall;
`endif

  int tests;
  int fails;

  debounce_switch #(
    .STABLE_TICKS(8),
    .SYNC_STEPS  (3),
    .INIT_LEVEL  (1'b0)
  ) dut (
    .in_clk       (clk),
    .in_rst       (in_rst),
    .in_signal    (in_signal),
    .out_debounced(out_debounced),
    .out_changed  (out_changed),
    .out_busy     (out_busy)
`ifdef DEBOUNCE_EDGE_OUT_EN
    ,
    .out_rise     (out_rise),
    .out_fall     (out_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_rst    = 1'b1;
    in_signal = 1'b0;
    step();
    step();
    in_rst = 1'b0;
  endtask

  task automatic test_reset();
    in_rst    = 1'b1;
    in_signal = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) in_rst = 1'b0;
      step();
      tests++;
      if ({out_debounced, out_changed, out_busy} !== 3'b000) begin
        fails++;
        $display("FAIL reset k=%0d got deb/chg/busy=%b exp 000", k,
                 {out_debounced, out_changed, out_busy});
      end
    end
    do_reset();
  endtask

  task automatic test_clean_rise();
    in_signal = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests++;
      if (out_debounced !== (k >= 11)) begin
        fails++;
        $display("FAIL rise_deb E%0d got %b exp %b", k, out_debounced, (k >= 11));
      end
      tests++;
      if (out_changed !== (k == 11)) begin
        fails++;
        $display("FAIL rise_chg E%0d got %b exp %b", k, out_changed, (k == 11));
      end
      if (k >= 4) begin
        tests++;
        if (out_busy !== (k <= 10)) begin
          fails++;
          $display("FAIL rise_busy E%0d got %b exp %b", k, out_busy, (k <= 10));
        end
      end
`ifdef DEBOUNCE_EDGE_OUT_EN
      tests++;
      if ({out_rise, out_fall} !== {(k == 11), 1'b0}) begin
        fails++;
        $display("FAIL rise_edges E%0d got rise/fall=%b%b exp %b0", k, out_rise, out_fall, (k == 11));
      end
`endif
    end
  endtask

  task automatic test_glitch();
    logic saw_busy;
    logic saw_chg;
    logic saw_deb;
    saw_busy = 1'b0;
    saw_chg  = 1'b0;
    saw_deb  = 1'b0;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      in_signal = (k <= 5);
      step();
      saw_busy |= out_busy;
      saw_chg  |= out_changed;
      saw_deb  |= out_debounced;
    end
    tests++;
    if (saw_busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy_seen got %b exp 1", saw_busy);
    end
    tests++;
    if (saw_chg !== 1'b0) begin
      fails++;
      $display("FAIL glitch_changed got %b exp 0", saw_chg);
    end
    tests++;
    if (saw_deb !== 1'b0) begin
      fails++;
      $display("FAIL glitch_deb got %b exp 0", saw_deb);
    end
    tests++;
    if (out_busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy_end got %b exp 0", out_busy);
    end
  endtask

  task automatic test_bounce();
    int pulses;
    int at;
    pulses = 0;
    at     = -1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      in_signal = ((i / 3) % 2 == 0);
      step();
      if (out_changed) pulses++;
    end
    in_signal = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step();
      if (out_changed) begin
        pulses++;
        at = j;
      end
    end
    tests++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL bounce_pulses got %0d exp 1", pulses);
    end
    tests++;
    if (at !== 11) begin
      fails++;
      $display("FAIL bounce_latency got %0d exp 11", at);
    end
    tests++;
    if (out_debounced !== 1'b1) begin
      fails++;
      $display("FAIL bounce_deb got %b exp 1", out_debounced);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_signal = 1'b1;
    for (int k = 1; k <= 8; k++) step();
    tests++;
    if (out_busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy_before got %b exp 1", out_busy);
    end
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    tests++;
    if ({out_debounced, out_changed, out_busy} !== 3'b000) begin
      fails++;
      $display("FAIL mid_reset got deb/chg/busy=%b exp 000",
               {out_debounced, out_changed, out_busy});
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      tests++;
      if ({out_debounced, out_changed} !== {(k >= 11), (k == 11)}) begin
        fails++;
        $display("FAIL mid_recommit E%0d got deb/chg=%b%b exp %b%b", k,
                 out_debounced, out_changed, (k >= 11), (k == 11));
      end
    end
  endtask

  task automatic test_fall();
    in_signal = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests++;
      if ({out_debounced, out_changed} !== {(k < 11), (k == 11)}) begin
        fails++;
        $display("FAIL fall E%0d got deb/chg=%b%b exp %b%b", k,
                 out_debounced, out_changed, (k < 11), (k == 11));
      end
`ifdef DEBOUNCE_EDGE_OUT_EN
      tests++;
      if ({out_rise, out_fall} !== {1'b0, (k == 11)}) begin
        fails++;
        $display("FAIL fall_edges E%0d got rise/fall=%b%b exp 0%b", k, out_rise, out_fall, (k == 11));
      end
`endif
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    in_rst    = 1'b1;
    in_signal = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_fall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
